// File: rtl/tc_word_assembler.sv
// tc_word_assembler
//   Deserialises a serial bit stream (LSB first) into WIDTH-bit words for the
//   bit-transition counter. Each finished word is parked until Ready, then
//   presented on Data together with a one-cycle Load strobe.
//
//   Optional feature macro: PARITY_CHECK_EN
//     defined   -> frame is WIDTH+1 bits, the last bit is even parity over the
//                  whole frame; a bad frame is dropped with a Par_Err pulse.
//     undefined -> frame is WIDTH bits and Par_Err is tied low.
//
//   Delivery handshake: a finished word sits in HOLD; on any rising edge
//   where Ready=1 the word is copied to Data and Load is raised for exactly
//   the following cycle. Ready=0 stalls delivery by whole cycles and never
//   loses the word. Load carries no back-pressure of its own: the counter
//   must take Data in the cycle Load is high. Data only changes on the edge
//   that raises Load and is held otherwise.
module tc_word_assembler #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             Bit_In,
    input  logic             Bit_Valid,
    input  logic             Frame_Abort,
    input  logic             Ready,
    input  logic             Ovr_Clr,
    output logic [WIDTH-1:0] Data,
    output logic             Load,
    output logic             Busy,
    output logic             Overrun,
    output logic             Par_Err,
    output logic [1:0]       dbg_state
);

`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    // Bit-count value at which the incoming bit closes the frame.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    // Current FSM state, exported for checkers and debug visibility.
    assign dbg_state = state;

`ifdef PARITY_CHECK_EN
    // Even parity over the whole frame: the stored data bits plus the
    // parity bit arriving this cycle must XOR to zero.
    logic frame_bad;
    assign frame_bad = (^shreg) ^ Bit_In;
`else
    // Without parity checking there is never a frame error to report.
    assign Par_Err = 1'b0;
`endif

    // Main FSM: bit capture, word hand-off, abort, overrun and parity status.
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            Data    <= '0;
            Load    <= 1'b0;
            Busy    <= 1'b0;
            Overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            Par_Err <= 1'b0;
`endif
        end else begin
            // Strobes default low so they last exactly one cycle.
            Load <= 1'b0;
`ifdef PARITY_CHECK_EN
            Par_Err <= 1'b0;
`endif
            // Clear first; a set later in this block overrides it.
            if (Ovr_Clr) begin
                Overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (Bit_Valid) begin
                        shreg[0] <= Bit_In;
                        cnt      <= ONE_CNT;
                        state    <= COLLECT;
                        Busy     <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (Frame_Abort) begin
                        // Partial word discarded; a same-cycle bit is dropped
                        // silently and Data keeps the last delivered word.
                        cnt   <= '0;
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (Bit_Valid) begin
                        // A parity bit (cnt == WIDTH) is checked, not stored.
                        for (int i = 0; i < WIDTH; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                shreg[i] <= Bit_In;
                            end
                        end
                        if (cnt == LAST_CNT) begin
                            cnt <= '0;
`ifdef PARITY_CHECK_EN
                            if (frame_bad) begin
                                Par_Err <= 1'b1;
                                state   <= IDLE;
                                Busy    <= 1'b0;
                            end else begin
                                state <= HOLD;
                            end
`else
                            state <= HOLD;
`endif
                        end else begin
                            cnt <= cnt + ONE_CNT;
                        end
                    end
                end

                HOLD: begin
                    if (Ready) begin
                        Data <= shreg;
                        Load <= 1'b1;
                        if (Bit_Valid) begin
                            // The delivering edge also starts the next word.
                            shreg[0] <= Bit_In;
                            cnt      <= ONE_CNT;
                            state    <= COLLECT;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end else if (Bit_Valid) begin
                        // No room for this bit while the word waits.
                        Overrun <= 1'b1;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_word_assembler.sv
// Bench for tc_word_assembler: table-driven basic word, hand-written corner
// sequences, then randomized traffic checked against a queue-based model.
module tb_tc_word_assembler;

    localparam int WIDTH = 10;
    localparam int CNT_W = 4;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             CLK = 1'b0;
    logic             Clear;
    logic             Bit_In;
    logic             Bit_Valid;
    logic             Frame_Abort;
    logic             Ready;
    logic             Ovr_Clr;
    logic [WIDTH-1:0] Data;
    logic             Load;
    logic             Busy;
    logic             Overrun;
    logic             Par_Err;
    logic [1:0]       dbg_state;

    tc_word_assembler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .Clear       (Clear),
        .Bit_In      (Bit_In),
        .Bit_Valid   (Bit_Valid),
        .Frame_Abort (Frame_Abort),
        .Ready       (Ready),
        .Ovr_Clr     (Ovr_Clr),
        .Data        (Data),
        .Load        (Load),
        .Busy        (Busy),
        .Overrun     (Overrun),
        .Par_Err     (Par_Err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- counters ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int load_cnt = 0;
    int load_cyc_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words are tracked as a list of received bits; a word is "held" once a
    // full frame has arrived and waits for Ready.
    logic             m_bits[$];
    logic             m_have;
    logic [WIDTH-1:0] m_word;
    logic [WIDTH-1:0] m_data;
    logic             m_load;
    logic             m_ovr;
    logic             m_par;
    logic [WIDTH-1:0] exp_q[$];

    task automatic model_reset();
        m_bits.delete();
        exp_q.delete();
        m_have = 1'b0;
        m_word = '0;
        m_data = '0;
        m_load = 1'b0;
        m_ovr  = 1'b0;
        m_par  = 1'b0;
    endtask

    task automatic model_step(input logic bv, input logic b, input logic ab,
                              input logic rd, input logic oc);
        logic [WIDTH-1:0] w;
        logic             p;
        m_load = 1'b0;
        m_par  = 1'b0;
        if (oc) m_ovr = 1'b0;
        if (m_have) begin
            if (rd) begin
                m_data = m_word;
                m_load = 1'b1;
                m_have = 1'b0;
                if (bv) m_bits.push_back(b);
            end else if (bv) begin
                m_ovr = 1'b1;
            end
        end else if (m_bits.size() > 0 && ab) begin
            m_bits.delete();
        end else if (bv) begin
            m_bits.push_back(b);
            if (m_bits.size() == FRAME) begin
                w = '0;
                p = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i < WIDTH) w[i] = m_bits[i];
                    p = p ^ m_bits[i];
                end
                m_bits.delete();
                if (FRAME > WIDTH && p) begin
                    m_par = 1'b1;
                end else begin
                    m_have = 1'b1;
                    m_word = w;
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [WIDTH-1:0] w;
        logic             busy_exp;
        busy_exp = m_have || (m_bits.size() > 0);
        check("load", Load, m_load);
        check("busy", Busy, busy_exp);
        check("overrun", Overrun, m_ovr);
        check("par_err", Par_Err, m_par);
        check("data", Data, m_data);
        if (m_load) begin
            w = exp_q.pop_front();
            check("word_order", Data, w);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic bv, input logic b, input logic ab,
                         input logic rd, input logic oc);
        Bit_Valid   = bv;
        Bit_In      = b;
        Frame_Abort = ab;
        Ready       = rd;
        Ovr_Clr     = oc;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (Load === 1'b1) begin
            load_cnt++;
            load_cyc_q.push_back(cyc);
        end
    endtask

    task automatic cycle(input logic bv, input logic b, input logic ab,
                         input logic rd, input logic oc);
        drive(bv, b, ab, rd, oc);
        step();
        model_step(bv, b, ab, rd, oc);
        compare_all();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic pbit, input logic rd);
        for (int i = 0; i < WIDTH; i++) cycle(1'b1, w[i], 1'b0, rd, 1'b0);
`ifdef PARITY_CHECK_EN
        cycle(1'b1, pbit, 1'b0, rd, 1'b0);
`endif
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic rd);
        send_frame(w, ^w, rd);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             bv;
        logic             b;
        logic             ab;
        logic             rd;
        logic             oc;
        logic             e_load;
        logic             e_busy;
        logic             e_ovr;
        logic [WIDTH-1:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkvec(input logic bv, input logic b, input logic ab,
                                   input logic rd, input logic oc, input logic e_load,
                                   input logic e_busy, input logic e_ovr,
                                   input logic [WIDTH-1:0] e_data);
        vec_t v;
        v.bv = bv; v.b = b; v.ab = ab; v.rd = rd; v.oc = oc;
        v.e_load = e_load; v.e_busy = e_busy; v.e_ovr = e_ovr; v.e_data = e_data;
        return v;
    endfunction

    // ---------------- test ----------------
    initial begin
        logic [WIDTH-1:0] pat;
        logic [WIDTH-1:0] w1;
        logic [WIDTH-1:0] w2;
        logic             bb[$];
        int               l0;

        pat = 10'b1101001101;
        for (int i = 0; i < WIDTH; i++)
            vecs.push_back(mkvec(1'b1, pat[i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0));
`ifdef PARITY_CHECK_EN
        vecs.push_back(mkvec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0));
`endif
        vecs.push_back(mkvec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'b1101001101));
        vecs.push_back(mkvec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'b1101001101));

        // reset
        Clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        step();
        step();
        check("rst_data", Data, 0);
        check("rst_load", Load, 0);
        check("rst_busy", Busy, 0);
        check("rst_overrun", Overrun, 0);
        check("rst_par_err", Par_Err, 0);
        Clear = 1'b0;

        // basic word from the table
        foreach (vecs[k]) begin
            drive(vecs[k].bv, vecs[k].b, vecs[k].ab, vecs[k].rd, vecs[k].oc);
            step();
            model_step(vecs[k].bv, vecs[k].b, vecs[k].ab, vecs[k].rd, vecs[k].oc);
            check("vec_load", Load, vecs[k].e_load);
            check("vec_busy", Busy, vecs[k].e_busy);
            check("vec_ovr", Overrun, vecs[k].e_ovr);
            check("vec_data", Data, vecs[k].e_data);
            compare_all();
        end

        // overrun while the word waits for Ready
        send_word(10'h2A5, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_set", Overrun, 1);
        check("ovr_no_load", Load, 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("ovr_set_beats_clr", Overrun, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_late_load", Load, 1);
        check("ovr_late_data", Data, 10'h2A5);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_cleared", Overrun, 0);

        // back-to-back words with Bit_Valid held high
        w1 = WIDTH'($urandom);
        w2 = WIDTH'($urandom);
        for (int i = 0; i < WIDTH; i++) bb.push_back(w1[i]);
`ifdef PARITY_CHECK_EN
        bb.push_back(^w1);
`endif
        for (int i = 0; i < WIDTH; i++) bb.push_back(w2[i]);
`ifdef PARITY_CHECK_EN
        bb.push_back(^w2);
`endif
        load_cyc_q.delete();
        l0 = load_cnt;
        foreach (bb[i]) cycle(1'b1, bb[i], 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_loads", load_cnt - l0, 2);
        if (load_cyc_q.size() == 2) check("b2b_gap", load_cyc_q[1] - load_cyc_q[0], FRAME);
        else check("b2b_gap_count", load_cyc_q.size(), 2);
        check("b2b_data", Data, w2);
        check("b2b_ovr", Overrun, 0);

        // abort after 6 bits, abort beats a same-cycle bit
        l0 = load_cnt;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("abort_busy", Busy, 0);
        check("abort_ovr", Overrun, 0);
        check("abort_data_kept", Data, w2);
        send_word(10'h3FF, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_loads", load_cnt - l0, 1);
        check("abort_data", Data, 10'h3FF);

        // asynchronous clear mid-word
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        Clear = 1'b1;
        #1;
        check("aclr_data", Data, 0);
        check("aclr_load", Load, 0);
        check("aclr_busy", Busy, 0);
        check("aclr_overrun", Overrun, 0);
        check("aclr_par_err", Par_Err, 0);
        model_reset();
        step();
        check("aclr_held_busy", Busy, 0);
        Clear = 1'b0;
        send_word(10'h155, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post_clr_load", Load, 1);
        check("post_clr_data", Data, 10'h155);

`ifdef PARITY_CHECK_EN
        // parity good / bad
        send_frame(10'h001, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("par_ok_load", Load, 1);
        check("par_ok_data", Data, 10'h001);
        l0 = load_cnt;
        send_frame(10'h001, 1'b0, 1'b1);
        check("par_bad_pulse", Par_Err, 1);
        check("par_bad_busy", Busy, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("par_bad_pulse_end", Par_Err, 0);
        check("par_bad_no_load", load_cnt - l0, 0);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) < 4),
                  1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 99) < 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
